pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register for the pipelined RISC-V core; the general replacement for the fixed per-stage register pairs.
- Carries a datapath bundle and a controller bundle as separate fields, with a valid/ready handshake and a two-entry skid buffer so upstream ready is registered.
- Supports synchronous flush, which inserts bubbles whose control bits are forced to a safe value.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_pkg.sv | 13 +
 rtl/pipe_stage_slot.sv | 32 +++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the pipeline-stage register.
// Optional statistics ports are enabled with PIPE_STAGE_STATS_EN (see pipe_stage_reg).
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } occ_t;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage slot of a pipeline stage: datapath + controller bundle with
// load enable; clear forces only the controller bits to the bubble value.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned           DP_W      = 133,
  parameter int unsigned           CR_W      = 3,
  parameter logic [CR_W-1:0]       CR_BUBBLE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [DP_W-1:0] in_dp,
  input  logic [CR_W-1:0] in_cr,
  output logic [DP_W-1:0] dp,
  output logic [CR_W-1:0] cr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp <= '0;
      cr <= CR_BUBBLE;
    end else if (clear) begin
      cr <= CR_BUBBLE;
    end else if (load) begin
      dp <= in_dp;
      cr <= in_cr;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer
// and flush. Define PIPE_STAGE_STATS_EN to add stall_cnt/flush_cnt ports.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned     DP_W      = 133,
  parameter int unsigned     CR_W      = 3,
  parameter logic [CR_W-1:0] CR_BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DP_W-1:0]  in_dp,
  input  logic [CR_W-1:0]  in_cr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DP_W-1:0]  out_dp,
  output logic [CR_W-1:0]  out_cr,
  input  logic             flush
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  occ_t            state, state_nx;
  logic            in_ready_q;
  logic            accept, emit;
  logic            main_ld, skid_ld, main_from_skid;
  logic [DP_W-1:0] main_dp, skid_dp, main_in_dp;
  logic [CR_W-1:0] main_cr, skid_cr, main_in_cr;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != FULL);
    end
  end

  always_comb begin
    state_nx       = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_ld  = 1'b1;
            state_nx = HALF;
          end
        end
        HALF: begin
          if (accept && !emit) begin
            skid_ld  = 1'b1;
            state_nx = FULL;
          end else if (accept && emit) begin
            main_ld = 1'b1;
          end else if (emit) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so the only possible move is skid -> main
          if (emit) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_nx       = HALF;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  assign main_in_dp = main_from_skid ? skid_dp : in_dp;
  assign main_in_cr = main_from_skid ? skid_cr : in_cr;

  pipe_stage_slot #(
    .DP_W      (DP_W),
    .CR_W      (CR_W),
    .CR_BUBBLE (CR_BUBBLE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_ld),
    .clear (flush),
    .in_dp (main_in_dp),
    .in_cr (main_in_cr),
    .dp    (main_dp),
    .cr    (main_cr)
  );

  pipe_stage_slot #(
    .DP_W      (DP_W),
    .CR_W      (CR_W),
    .CR_BUBBLE (CR_BUBBLE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_ld),
    .clear (flush),
    .in_dp (in_dp),
    .in_cr (in_cr),
    .dp    (skid_dp),
    .cr    (skid_cr)
  );

  // main cr is stale after a drain to EMPTY, so mask it with the bubble
  assign out_dp = main_dp;
  assign out_cr = out_valid ? main_cr : CR_BUBBLE;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based FIFO model checked
// every cycle, plus directed literal expectations from the test plan.
module tb_pipe_stage_reg;
  import pipe_stage_pkg::*;

  localparam int unsigned DP_W = 133;
  localparam int unsigned CR_W = 3;
  localparam logic [CR_W-1:0] BUB = '0;

  typedef struct {
    logic [DP_W-1:0] dp;
    logic [CR_W-1:0] cr;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DP_W-1:0] in_dp = '0;
  logic [CR_W-1:0] in_cr = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DP_W-1:0] out_dp;
  logic [CR_W-1:0] out_cr;
  logic            flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipe_stage_reg #(
    .DP_W      (DP_W),
    .CR_W      (CR_W),
    .CR_BUBBLE (BUB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dp     (in_dp),
    .in_cr     (in_cr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dp    (out_dp),
    .out_cr    (out_cr),
    .flush     (flush)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: bounded FIFO of depth 2, ready computed from occupancy
  ent_t            q[$];
  logic [DP_W-1:0] log_q[$];
  logic            ready_m = 1'b1;
  logic            acc_m, em_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ready_m = 1'b1;
    end else begin
      acc_m = in_valid && ready_m;
      em_m  = (q.size() > 0) && out_ready;
      if (em_m) log_q.push_back(q[0].dp);
      if (flush) begin
        q.delete();
      end else begin
        if (em_m) void'(q.pop_front());
        if (acc_m) q.push_back('{dp: in_dp, cr: in_cr});
      end
      ready_m = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 140'(in_ready), 140'(ready_m));
      chk("out_valid", 140'(out_valid), 140'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_dp", 140'(out_dp), 140'(q[0].dp));
        chk("out_cr", 140'(out_cr), 140'(q[0].cr));
      end else begin
        chk("out_cr_bubble", 140'(out_cr), 140'(BUB));
      end
    end
  end

  task automatic step(input logic v, input logic [DP_W-1:0] d, input logic [CR_W-1:0] c,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_dp     = d;
    in_cr     = c;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_out_valid", 140'(out_valid), 140'(0));
    chk("rst_out_cr", 140'(out_cr), 140'(BUB));
    chk("rst_in_ready", 140'(in_ready), 140'(1));
    chk("rst_out_dp", 140'(out_dp), 140'(0));
    rst = 1'b0;

    // streaming at full rate
    log_q.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DP_W'(i), 3'b101, 1'b1, 1'b0);
      if (i == 1) begin
        chk("lat1_valid", 140'(out_valid), 140'(1));
        chk("lat1_dp", 140'(out_dp), 140'(1));
      end
      chk("stream_in_ready", 140'(in_ready), 140'(1));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_count", 140'(log_q.size()), 140'(8));
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) chk("stream_order", 140'(log_q[i]), 140'(i + 1));

    // fill to FULL, then drain
    log_q.delete();
    step(1'b1, 'hA, 3'b011, 1'b0, 1'b0);
    step(1'b1, 'hB, 3'b110, 1'b0, 1'b0);
    chk("full_in_ready", 140'(in_ready), 140'(0));
    chk("full_out_dp", 140'(out_dp), 140'('hA));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_out_dp", 140'(out_dp), 140'('hB));
    chk("drain_in_ready", 140'(in_ready), 140'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_count", 140'(log_q.size()), 140'(2));
    if (log_q.size() == 2) begin
      chk("drain_first", 140'(log_q[0]), 140'('hA));
      chk("drain_second", 140'(log_q[1]), 140'('hB));
    end

    // flush while FULL with an incoming entry
    log_q.delete();
    step(1'b1, 'hA, 3'b011, 1'b0, 1'b0);
    step(1'b1, 'hB, 3'b110, 1'b0, 1'b0);
    step(1'b1, 'hC, 3'b111, 1'b0, 1'b1);
    chk("flush_valid", 140'(out_valid), 140'(0));
    chk("flush_cr", 140'(out_cr), 140'(BUB));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_nothing_out", 140'(log_q.size()), 140'(0));

    // HALF with simultaneous accept and emit
    log_q.delete();
    step(1'b1, 'hA1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 'hD, 3'b100, 1'b1, 1'b0);
    chk("half_swap_valid", 140'(out_valid), 140'(1));
    chk("half_swap_dp", 140'(out_dp), 140'('hD));
    chk("half_swap_ready", 140'(in_ready), 140'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("half_swap_count", 140'(log_q.size()), 140'(2));

    // asynchronous reset while FULL
    step(1'b1, 'hA, 3'b011, 1'b0, 1'b0);
    step(1'b1, 'hB, 3'b110, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 140'(out_valid), 140'(0));
    chk("arst_in_ready", 140'(in_ready), 140'(1));
    chk("arst_cr", 140'(out_cr), 140'(BUB));
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 'hE, 3'b001, 1'b1, 1'b0);
    chk("post_rst_dp", 140'(out_dp), 140'('hE));
    chk("post_rst_cr", 140'(out_cr), 140'(3'b001));
    step(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 'hA, 3'b011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    chk("stall_cnt", 140'(stall_cnt), 140'(5));
    chk("flush_cnt", 140'(flush_cnt), 140'(2));
    force dut.stall_cnt_q = '1;
    step(1'b1, 'hB, 3'b011, 1'b0, 1'b0);
    release dut.stall_cnt_q;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall_sat", 140'(stall_cnt), 140'(32'hFFFF_FFFF));
    step(1'b0, '0, '0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
